// File: rtl/sincos_pkg.sv
// sincos_pkg: shared fixed-point format and constants for the phase generator
// and the sine/cosine approximation stages.
//   fix_t          signed Q19.8 angle word
//   PI_Q8 etc.     pi, pi/2 and 2*pi in Q19.8
//   phase_state_t  phase generator sequencing states
package sincos_pkg;

    typedef logic signed [26:0] fix_t;

    localparam int PI_Q8      = 804;
    localparam int HALF_PI_Q8 = 402;
    localparam int TWO_PI_Q8  = 1608;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } phase_state_t;

endpackage

// File: rtl/phase_wrap.sv
// phase_wrap: combinational add-and-wrap of two signed Q19.8 angles into [-pi, pi).
//   a, b  in  W  signed addends
//   y     out W  wrapped sum
// A single +/- 2*pi correction is enough for sums in [-2*pi, 2*pi).
module phase_wrap
    import sincos_pkg::*;
#(
    parameter int W = 27
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

    localparam logic signed [W:0] PI_S     = (W+1)'(PI_Q8);
    localparam logic signed [W:0] NEG_PI_S = (W+1)'(-PI_Q8);
    localparam logic signed [W:0] TWO_PI_S = (W+1)'(TWO_PI_Q8);

    logic signed [W:0] sum;
    logic signed [W:0] wsum;

    // One extra bit so the raw sum cannot overflow.
    assign sum = {a[W-1], a} + {b[W-1], b};

    always_comb begin
        wsum = sum;
        if (sum >= PI_S) begin
            wsum = sum - TWO_PI_S;
        end else if (sum < NEG_PI_S) begin
            wsum = sum + TWO_PI_S;
        end
    end

    assign y = wsum[W-1:0];

endmodule

// File: rtl/phase_gen.sv
// phase_gen: emits a run of wrapped angle samples (and their quadrature
// partners) after a start pulse, one per un-held cycle.
//   clk, reset          clock, async active-high reset
//   start               begin a run (accepted only when idle and not busy)
//   init_phase, step    initial phase and increment, latched on start
//   num_samples         run length, latched on start
//   hold                stall generation for this cycle
//   angle_sin/angle_cos wrapped phase and phase + pi/2
//   valid, en           new sample present / registered ~hold during RUN
//   busy, done          run in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// RUN   | emitting one sample per cycle without hold
// DONE  | last sample emitted; done pulse is registered here
module phase_gen
    import sincos_pkg::*;
#(
    parameter int W     = 27,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W-1:0] init_phase,
    input  logic signed [W-1:0] step,
    input  logic [CNT_W-1:0]    num_samples,
    input  logic                hold,
    output logic signed [W-1:0] angle_sin,
    output logic signed [W-1:0] angle_cos,
    output logic                valid,
    output logic                en,
    output logic                busy,
    output logic                done
);

    localparam logic signed [W-1:0] STEP_MAX  = W'(PI_Q8 - 1);
    localparam logic signed [W-1:0] STEP_MIN  = W'(-(PI_Q8 - 1));
    localparam logic signed [W-1:0] HALF_PI_W = W'(HALF_PI_Q8);

    phase_state_t state, state_nx;

    logic signed [W-1:0] phase_q;
    logic signed [W-1:0] step_q;
    logic [CNT_W-1:0]    count_q;

    logic signed [W-1:0] wrap_a, wrap_b, wrap_y;
    logic signed [W-1:0] cos_y;
    logic signed [W-1:0] step_sat;
    logic                start_ok;
    logic                advance;

    // busy stays high through the done cycle, so a start there is ignored.
    assign start_ok = start && (state == IDLE) && !busy;
    assign advance  = (state == RUN) && !hold;

    always_comb begin
        step_sat = step;
        if (step > STEP_MAX) begin
            step_sat = STEP_MAX;
        end else if (step < STEP_MIN) begin
            step_sat = STEP_MIN;
        end
    end

    // The phase adder doubles as the initial-phase wrapper while idle.
    always_comb begin
        state_nx = state;
        wrap_a   = phase_q;
        wrap_b   = step_q;
        case (state)
            IDLE: begin
                wrap_a = init_phase;
                wrap_b = '0;
                if (start_ok) begin
                    state_nx = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!hold && count_q == CNT_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    phase_wrap #(.W(W)) u_wrap_phase (
        .a (wrap_a),
        .b (wrap_b),
        .y (wrap_y)
    );

    phase_wrap #(.W(W)) u_wrap_quad (
        .a (phase_q),
        .b (HALF_PI_W),
        .y (cos_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase_q   <= '0;
            step_q    <= '0;
            count_q   <= '0;
            angle_sin <= '0;
            angle_cos <= '0;
            valid     <= 1'b0;
            en        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == DONE);
            busy  <= (state != IDLE) || (state_nx != IDLE);
            valid <= advance;
            en    <= advance;
            if (start_ok) begin
                phase_q <= wrap_y;
                step_q  <= step_sat;
                count_q <= num_samples;
            end
            if (advance) begin
                angle_sin <= phase_q;
                angle_cos <= cos_y;
                phase_q   <= wrap_y;
                count_q   <= count_q - CNT_W'(1);
            end
        end
    end

endmodule
